// File: rtl/apb2ahb_if.sv
// Bus bundle for the APB-completer / AHB-Lite-manager bridge.
// The slave view is the bridge; the master view is everything around it.
interface apb2ahb_if #(
   parameter int unsigned ADDR = 24,
   parameter int unsigned DATA = 32
);
   logic            psel;
   logic            penable;
   logic [2:0]      pprot;
   logic [ADDR-1:0] paddr;
   logic            pwrite;
   logic [DATA-1:0] pwdata;
   logic [3:0]      pstrb;
   logic [DATA-1:0] prdata;
   logic            pslverr;
   logic            pready;

   logic [1:0]      htrans;
   logic [2:0]      hburst;
   logic [2:0]      hsize;
   logic [3:0]      hprot;
   logic            hmastlock;
   logic [ADDR-1:0] haddr;
   logic            hwrite;
   logic [DATA-1:0] hwdata;
   logic [DATA-1:0] hrdata;
   logic            hresp;
   logic            hready;

   modport slave (
      input  psel, penable, pprot, paddr, pwrite, pwdata, pstrb,
      output prdata, pslverr, pready,
      output htrans, hburst, hsize, hprot, hmastlock, haddr, hwrite, hwdata,
      input  hrdata, hresp, hready
   );

   modport master (
      output psel, penable, pprot, paddr, pwrite, pwdata, pstrb,
      input  prdata, pslverr, pready,
      input  htrans, hburst, hsize, hprot, hmastlock, haddr, hwrite, hwdata,
      output hrdata, hresp, hready
   );
endinterface

// File: rtl/apb2ahb.sv
// APB completer to AHB-Lite manager bridge: each APB access becomes one
// AHB SINGLE transfer (or none for empty/illegal write strobes).
module apb2ahb #(
   parameter int unsigned ADDR = 24,
   parameter int unsigned DATA = 32
) (
   input  logic     clk,
   input  logic     reset,
   apb2ahb_if.slave bus
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   state_t          r_state,   w_state_nxt;
   logic [1:0]      r_htrans,  w_htrans_nxt;
   logic [ADDR-1:0] r_haddr,   w_haddr_nxt;
   logic            r_hwrite,  w_hwrite_nxt;
   logic [2:0]      r_hsize,   w_hsize_nxt;
   logic [3:0]      r_hprot,   w_hprot_nxt;
   logic [DATA-1:0] r_hwdata,  w_hwdata_nxt;
   logic [DATA-1:0] r_prdata,  w_prdata_nxt;
   logic            r_pready,  w_pready_nxt;
   logic            r_pslverr, w_pslverr_nxt;

   logic            w_start;
   logic            w_strb_ok;
   logic [2:0]      w_strb_size;
   logic [1:0]      w_strb_off;
   logic            w_unused_ok;

   assign w_start     = bus.psel & bus.penable & ~r_pready;
   // pprot[1] has no AHB counterpart; low address bits come from the strobes
   assign w_unused_ok = ^{bus.pprot[1], bus.paddr[1:0]};

   // Write strobe pattern -> AHB transfer size and byte offset
   always_comb begin
      w_strb_ok   = 1'b1;
      w_strb_size = HSIZE_WORD;
      w_strb_off  = 2'd0;
      case (bus.pstrb)
         4'b1111: w_strb_size = HSIZE_WORD;
         4'b0011: w_strb_size = HSIZE_HALF;
         4'b1100: begin w_strb_size = HSIZE_HALF; w_strb_off = 2'd2; end
         4'b0001: w_strb_size = HSIZE_BYTE;
         4'b0010: begin w_strb_size = HSIZE_BYTE; w_strb_off = 2'd1; end
         4'b0100: begin w_strb_size = HSIZE_BYTE; w_strb_off = 2'd2; end
         4'b1000: begin w_strb_size = HSIZE_BYTE; w_strb_off = 2'd3; end
         default: w_strb_ok = 1'b0;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_htrans_nxt  = r_htrans;
      w_haddr_nxt   = r_haddr;
      w_hwrite_nxt  = r_hwrite;
      w_hsize_nxt   = r_hsize;
      w_hprot_nxt   = r_hprot;
      w_hwdata_nxt  = r_hwdata;
      w_prdata_nxt  = r_prdata;
      w_pready_nxt  = 1'b0;
      w_pslverr_nxt = r_pslverr;

      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (!bus.pwrite || w_strb_ok) begin
                  w_htrans_nxt = HTRANS_NONSEQ;
                  w_haddr_nxt  = bus.pwrite ? {bus.paddr[ADDR-1:2], w_strb_off}
                                            : {bus.paddr[ADDR-1:2], 2'b00};
                  w_hsize_nxt  = bus.pwrite ? w_strb_size : HSIZE_WORD;
                  w_hwrite_nxt = bus.pwrite;
                  w_hprot_nxt  = {2'b00, bus.pprot[0], ~bus.pprot[2]};
                  w_hwdata_nxt = bus.pwdata;
                  w_state_nxt  = S_ADDR;
               end else begin
                  // Empty strobe completes quietly; any other pattern is an error
                  w_pready_nxt  = 1'b1;
                  w_pslverr_nxt = (bus.pstrb != 4'b0000);
                  w_state_nxt   = S_RESP;
               end
            end
         end
         S_ADDR: begin
            if (bus.hready) begin
               w_htrans_nxt = HTRANS_IDLE;
               w_state_nxt  = S_DATA;
            end
         end
         S_DATA: begin
            // hresp with hready low is the first ERROR cycle and is ignored
            if (bus.hready) begin
               if (!r_hwrite) begin
                  w_prdata_nxt = bus.hrdata;
               end
               w_pslverr_nxt = bus.hresp;
               w_pready_nxt  = 1'b1;
               w_state_nxt   = S_RESP;
            end
         end
         S_RESP: begin
            w_pslverr_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
         end
         default: begin
            w_htrans_nxt = HTRANS_IDLE;
            w_state_nxt  = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_htrans  <= HTRANS_IDLE;
         r_haddr   <= '0;
         r_hwrite  <= 1'b0;
         r_hsize   <= HSIZE_WORD;
         r_hprot   <= 4'b0000;
         r_hwdata  <= '0;
         r_prdata  <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_htrans  <= w_htrans_nxt;
         r_haddr   <= w_haddr_nxt;
         r_hwrite  <= w_hwrite_nxt;
         r_hsize   <= w_hsize_nxt;
         r_hprot   <= w_hprot_nxt;
         r_hwdata  <= w_hwdata_nxt;
         r_prdata  <= w_prdata_nxt;
         r_pready  <= w_pready_nxt;
         r_pslverr <= w_pslverr_nxt;
      end
   end

   assign bus.htrans    = r_htrans;
   assign bus.hburst    = 3'b000;
   assign bus.hmastlock = 1'b0;
   assign bus.haddr     = r_haddr;
   assign bus.hwrite    = r_hwrite;
   assign bus.hsize     = r_hsize;
   assign bus.hprot     = r_hprot;
   assign bus.hwdata    = r_hwdata;
   assign bus.prdata    = r_prdata;
   assign bus.pready    = r_pready;
   assign bus.pslverr   = r_pslverr;

endmodule

// File: tb/tb_apb2ahb.sv
// Bench for apb2ahb: directed plan cases plus randomized accesses, each
// checked cycle by cycle against expectations derived from the access rules.
module tb_apb2ahb;
   localparam int unsigned ADDR = 24;
   localparam int unsigned DATA = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   apb2ahb_if #(.ADDR(ADDR), .DATA(DATA)) bus ();
   apb2ahb #(.ADDR(ADDR), .DATA(DATA)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_prdata = 32'h0;
   logic [3:0]  legal_tbl [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One APB access with an AHB slave that inserts na address-phase and
   // nd data-phase wait cycles; err selects a two-cycle ERROR response.
   task automatic run_access(input logic wr, input logic [23:0] addr, input logic [31:0] wd,
                             input logic [3:0] strb, input logic [2:0] prot, input int na_in,
                             input int nd_in, input logic [31:0] rd, input logic err,
                             input logic drop);
      int n, off, last, na, nd, nonseq;
      logic legal, xfer, exp_err;
      logic [23:0] e_haddr;
      logic [2:0]  e_hsize;
      logic [3:0]  e_hprot;
      na = na_in; nd = nd_in; nonseq = 0;
      n = $countones(strb);
      off = 0;
      for (int i = 3; i >= 0; i--) if (strb[i]) off = i;
      if (!wr) begin n = 4; off = 0; end
      legal = (n == 4) || (n == 1) || (n == 2 && (off % 2) == 0 && strb[off+1]);
      xfer = !wr || (n != 0 && legal);
      exp_err = xfer ? err : (n != 0);
      if (!xfer) begin na = 0; nd = 0; end
      if (xfer && err && nd == 0) nd = 1;
      last = xfer ? 3 + na + nd : 1;
      e_haddr = {addr[23:2], 2'b00} + 24'(off);
      e_hsize = 3'($clog2(n));
      e_hprot = {2'b00, prot[0], ~prot[2]};

      @(negedge clk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr;
      bus.pwdata = wd; bus.pstrb = strb; bus.pprot = prot; bus.hready = 1'b1; bus.hresp = 1'b0;
      @(negedge clk);
      bus.penable = 1'b1;
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         chk("htrans", 32'(bus.htrans), (xfer && c <= 1 + na) ? 32'h2 : 32'h0);
         chk("pready", 32'(bus.pready), 32'(c == last));
         if (bus.htrans == 2'b10 && bus.hready) nonseq++;
         if (xfer && c == 1 + na) begin
            chk("haddr",  32'(bus.haddr),  32'(e_haddr));
            chk("hsize",  32'(bus.hsize),  32'(e_hsize));
            chk("hwrite", 32'(bus.hwrite), 32'(wr));
            chk("hprot",  32'(bus.hprot),  32'(e_hprot));
            chk("hburst_hmastlock", 32'({bus.hburst, bus.hmastlock}), 32'h0);
         end
         if (xfer && wr && c >= 2 + na && c <= 2 + na + nd)
            chk("hwdata", bus.hwdata, wd);
         if (c == last) begin
            if (xfer && !wr) exp_prdata = rd;
            chk("pslverr", 32'(bus.pslverr), 32'(exp_err));
            chk("prdata", bus.prdata, exp_prdata);
         end
         // AHB slave response for this cycle
         bus.hrdata = $urandom; bus.hresp = 1'b0; bus.hready = 1'b1;
         if (xfer) begin
            if (c < 1 + na) bus.hready = 1'b0;
            else if (c >= 2 + na && c < 2 + na + nd) begin
               bus.hready = 1'b0;
               if (err && c == 1 + na + nd) bus.hresp = 1'b1;
            end else if (c == 2 + na + nd) begin
               bus.hrdata = rd; bus.hresp = err;
            end
         end
         if ((drop && c == 1) || c == last) begin bus.psel = 1'b0; bus.penable = 1'b0; end
      end
      @(negedge clk);
      chk("nonseq_count", 32'(nonseq), 32'(xfer));
      chk("idle_pready", 32'(bus.pready), 32'h0);
      chk("idle_pslverr", 32'(bus.pslverr), 32'h0);
      chk("idle_htrans", 32'(bus.htrans), 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pprot = 3'b0; bus.paddr = '0; bus.pwrite = 1'b0;
      bus.pwdata = '0; bus.pstrb = 4'b0; bus.hrdata = 32'h0; bus.hresp = 1'b0; bus.hready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_htrans", 32'(bus.htrans), 32'h0);
      chk("rst_haddr", 32'(bus.haddr), 32'h0);
      chk("rst_hsize", 32'(bus.hsize), 32'h2);
      chk("rst_hprot_hwrite", 32'({bus.hprot, bus.hwrite}), 32'h0);
      chk("rst_hwdata", bus.hwdata, 32'h0);
      chk("rst_prdata", bus.prdata, 32'h0);
      chk("rst_pready_pslverr", 32'({bus.pready, bus.pslverr}), 32'h0);
      reset = 1'b0;

      run_access(1'b0, 24'h001234, 32'h0, 4'h0, 3'b000, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
      run_access(1'b1, 24'h000100, 32'h00AB0000, 4'b0100, 3'b001, 0, 0, 32'h0, 1'b0, 1'b0);
      run_access(1'b1, 24'h00FF10, 32'h12345678, 4'b1111, 3'b101, 2, 3, 32'h0, 1'b0, 1'b0);
      run_access(1'b0, 24'h000040, 32'h0, 4'h0, 3'b000, 0, 1, 32'hBAD0BAD0, 1'b1, 1'b0);
      run_access(1'b1, 24'h000200, 32'hCAFEF00D, 4'b0101, 3'b000, 0, 0, 32'h0, 1'b0, 1'b0);
      run_access(1'b1, 24'h000300, 32'hCAFEF00D, 4'b0000, 3'b000, 0, 0, 32'h0, 1'b0, 1'b0);

      // Reset while the data phase is stalled
      @(negedge clk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 24'h00ABC0; bus.hready = 1'b1;
      @(negedge clk);
      bus.penable = 1'b1;
      @(negedge clk);
      chk("rstop_nonseq", 32'(bus.htrans), 32'h2);
      @(negedge clk);
      chk("rstop_data", 32'(bus.htrans), 32'h0);
      bus.hready = 1'b0;
      @(negedge clk);
      chk("rstop_wait", 32'(bus.pready), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("rstop_htrans", 32'(bus.htrans), 32'h0);
      chk("rstop_pready", 32'(bus.pready), 32'h0);
      chk("rstop_haddr", 32'(bus.haddr), 32'h0);
      chk("rstop_prdata", bus.prdata, 32'h0);
      reset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0; bus.hready = 1'b1;
      exp_prdata = 32'h0;
      run_access(1'b0, 24'h0000A8, 32'h0, 4'h0, 3'b100, 0, 0, 32'h0BADC0DE, 1'b0, 1'b0);

      run_access(1'b0, 24'h003000, 32'h0, 4'h0, 3'b011, 1, 2, 32'h5A5A1234, 1'b0, 1'b1);

      for (int k = 0; k < 40; k++) begin
         logic [3:0] s;
         if ($urandom_range(0, 3) == 0) s = 4'($urandom);
         else s = legal_tbl[$urandom_range(0, 6)];
         run_access(1'($urandom), 24'($urandom), $urandom, s, 3'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/apb2ahb.md
Name: apb2ahb

Overview:
APB completer to AHB-Lite manager bridge; the reverse direction of the AHB-to-APB bridge. It lets an APB-side initiator (e.g. a DMA or debug port on the peripheral fabric) reach AHB-Lite memory space. Each APB access becomes exactly one AHB-Lite SINGLE transfer, or none. The APB transfer is held with pready low until the AHB data phase completes.

Parameters:
ADDR, 24, address width of both paddr and haddr
DATA, 32, data width of pwdata/prdata/hwdata/hrdata; fixed at 32 (hsize encoding and pstrb width depend on it)

Ports:
clk  input  1  single clock for APB and AHB sides
reset  input  1  synchronous, active-high reset
psel  input  1  APB select
penable  input  1  APB access phase
pprot  input  3  APB protection
paddr  input  ADDR  APB address
pwrite  input  1  APB write
pwdata  input  DATA  APB write data
pstrb  input  4  APB write strobes
prdata  output  DATA  APB read data
pslverr  output  1  APB error
pready  output  1  APB ready
htrans  output  2  AHB transfer type (IDLE=00, NONSEQ=10)
hburst  output  3  always 3'b000 (SINGLE)
hsize  output  3  000 byte, 001 half, 010 word
hprot  output  4  AHB protection
hmastlock  output  1  always 0
haddr  output  ADDR  AHB address
hwrite  output  1  AHB write
hwdata  output  DATA  AHB write data
hrdata  input  DATA  AHB read data
hresp  input  1  AHB error response
hready  input  1  AHB ready

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, htrans=00, haddr=0, hwrite=0, hsize=010, hprot=0000, hwdata=0, pready=0, pslverr=0, prdata=0. hburst and hmastlock are constant 0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE, start condition: psel&penable&~pready.
  - On start, latch paddr, pwrite, pwdata, pprot, pstrb.
  - Decode size. Reads are always word.
  - Write strobes: 1111 -> word, offset 0. 0011/1100 -> half, offset 0/2. 0001/0010/0100/1000 -> byte, offset 0/1/2/3.
  - Write with pstrb=0000 -> RESP with pslverr=0, no AHB transfer.
  - Write with any other pstrb pattern -> RESP with pslverr=1, no AHB transfer.
  - Otherwise -> ADDR.
- ADDR: htrans=NONSEQ; haddr={paddr[ADDR-1:2], offset}; hwrite, hsize and hprot valid.
  - hprot = {2'b00, pprot[0], ~pprot[2]}.
  - Stay in ADDR while hready=0. On hready=1 -> DATA.
- DATA: htrans=IDLE; hwdata=latched pwdata (full word; byte lanes per AHB addressing).
  - Stay while hready=0. hresp=1 with hready=0 (first cycle of an ERROR response) is ignored.
  - On hready=1: capture hrdata into prdata (reads only; writes leave prdata unchanged) and capture pslverr=hresp. Go to RESP.
- RESP: pready=1 for exactly one cycle, with pslverr/prdata valid -> IDLE.
  - pready is low in every other state. pslverr is cleared on leaving RESP.
- Latency with zero AHB wait states: the first penable cycle is T0, htrans=NONSEQ at T1, data phase at T2, pready=1 at T3. Each hready-low cycle adds one cycle.
- Back-to-back: a new APB access's penable cannot coincide with pready, so the next start is at the earliest the cycle after RESP.
- psel dropped mid-transfer (APB violation): the AHB transfer still completes and pready is still pulsed once. No new transfer starts.
- reset mid-operation: immediately return to reset values and drive htrans=IDLE next cycle. The outstanding AHB transfer is abandoned, which is acceptable only under a system-wide reset.
- Exactly one NONSEQ cycle per accepted access while hready=1.

Test Plan:
- Word read, paddr=24'h00_1234, hready always 1, hrdata=32'hDEADBEEF -> haddr=24'h001234, hsize=010, hwrite=0; pready at T3 with prdata=32'hDEADBEEF, pslverr=0.
- Byte write, paddr=24'h000100, pstrb=0100, pwdata=32'h00AB0000 -> haddr=24'h000102, hsize=000, hwdata=32'h00AB0000 in data phase; pready=1, pslverr=0.
- Wait states: word write with hready low for 2 cycles in ADDR and 3 cycles in DATA -> pready at T8; exactly one NONSEQ cycle sampled with hready=1.
- AHB ERROR: read with a 2-cycle ERROR response (hresp=1/hready=0, then hresp=1/hready=1) -> pslverr=1 on the pready cycle.
- Illegal strobe pstrb=0101 -> no NONSEQ ever driven; pready=1, pslverr=1 at T1. pstrb=0000 -> pready=1, pslverr=0, no AHB activity.
- Reset asserted while in DATA with hready low -> next cycle htrans=00, pready=0; a following read completes normally.
